sw_align_core: RTL and testbench

- Smith-Waterman local-alignment accelerator with affine gap scoring.
- Accepts one packed 2-bit-per-base reference/read pair through a valid/ready input handshake.
- Computes the best local alignment score and the 0-based (row, column) of the cell holding that score.
- Returns the result through a valid/ready output handshake; sits between the sequence loader and the result collector of the alignment pipeline.

---
 rtl/sw_pkg.sv | 30 +++
 rtl/sw_pe.sv | 73 +++++++
 rtl/sw_align_core.sv | 176 +++++++++++++++++
 tb/tb_sw_align_core.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared constants, score type and FSM encoding for the Smith-Waterman alignment core.
package sw_pkg;
  localparam int REF_MAX_LENGTH       = 128;
  localparam int READ_MAX_LENGTH      = 128;
  localparam int DP_SW_SCORE_BITWIDTH = 10;

  localparam int REF_IDX_W  = $clog2(REF_MAX_LENGTH);
  localparam int READ_IDX_W = $clog2(READ_MAX_LENGTH);
  localparam int REF_LEN_W  = REF_IDX_W + 1;
  localparam int READ_LEN_W = READ_IDX_W + 1;
  localparam int CNT_W      = $clog2(REF_MAX_LENGTH + READ_MAX_LENGTH) + 1;
  localparam int MERGE_CYCLES = 8;

  typedef logic signed [DP_SW_SCORE_BITWIDTH-1:0] score_t;

  localparam score_t MATCH      = score_t'(2);
  localparam score_t MISMATCH   = score_t'(-1);
  localparam score_t GAP_OPEN   = score_t'(2);
  localparam score_t GAP_EXTEND = score_t'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_MERGE, ST_OUT} state_e;

  function automatic score_t max2(input score_t a, input score_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic score_t clamp0(input score_t v);
    return (v < 0) ? '0 : v;
  endfunction
endpackage

// File: rtl/sw_pe.sv
// One systolic cell: owns one read base, scores one reference column per valid cycle
// and tracks the best H seen in its row together with the column where it occurred.
module sw_pe
  import sw_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_valid,
  input  logic [1:0]           i_base_ref,
  input  logic [1:0]           i_base_read,
  input  logic [REF_IDX_W-1:0] i_col,
  input  logic                 i_row_en,
  input  score_t               i_h_up,
  input  score_t               i_f_up,
  output logic                 o_valid,
  output logic [1:0]           o_base_ref,
  output logic [REF_IDX_W-1:0] o_col,
  output score_t               o_h,
  output score_t               o_f,
  output score_t               o_max,
  output logic [REF_IDX_W-1:0] o_max_col
);
  score_t r_h, r_e, r_f, r_diag, r_max;
  logic [REF_IDX_W-1:0] r_max_col, r_col;
  logic       r_valid;
  logic [1:0] r_base_ref;
  score_t w_e, w_f, w_diag, w_h;

  // E/F are kept clamped at zero; a negative gap score can never win H, so this is lossless.
  always_comb begin
    w_e    = clamp0(max2(r_h - GAP_OPEN, r_e - GAP_EXTEND));
    w_f    = clamp0(max2(i_h_up - GAP_OPEN, i_f_up - GAP_EXTEND));
    w_diag = clamp0(r_diag + ((i_base_ref == i_base_read) ? MATCH : MISMATCH));
    w_h    = max2(w_diag, max2(w_e, w_f));
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_h        <= '0;
      r_e        <= '0;
      r_f        <= '0;
      r_diag     <= '0;
      r_max      <= '0;
      r_max_col  <= '0;
      r_col      <= '0;
      r_valid    <= 1'b0;
      r_base_ref <= 2'b00;
    end else begin
      r_valid    <= i_valid;
      r_base_ref <= i_base_ref;
      r_col      <= i_col;
      if (i_valid) begin
        r_h    <= w_h;
        r_e    <= w_e;
        r_f    <= w_f;
        r_diag <= i_h_up;  // H(up, j) becomes the diagonal term for column j+1
        if (i_row_en && (w_h > r_max)) begin
          r_max     <= w_h;
          r_max_col <= i_col;
        end
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_base_ref = r_base_ref;
  assign o_col      = r_col;
  assign o_h        = r_h;
  assign o_f        = r_f;
  assign o_max      = r_max;
  assign o_max_col  = r_max_col;
endmodule

// File: rtl/sw_align_core.sv
// Smith-Waterman local alignment core: a linear PE array sweeps the DP wavefront,
// then a pipelined max-tree picks the best cell (lowest row, then lowest column, on ties).
module sw_align_core
  import sw_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  output logic                                   o_ready,
  input  logic                                   i_valid,
  input  logic [2*REF_MAX_LENGTH-1:0]            i_sequence_ref,
  input  logic [2*READ_MAX_LENGTH-1:0]           i_sequence_read,
  input  logic [REF_LEN_W-1:0]                   i_seq_ref_length,
  input  logic [READ_LEN_W-1:0]                  i_seq_read_length,
  input  logic                                   i_ready,
  output logic                                   o_valid,
  output logic signed [DP_SW_SCORE_BITWIDTH-1:0] o_alignment_score,
  output logic [REF_IDX_W-1:0]                   o_column,
  output logic [READ_IDX_W-1:0]                  o_row
);
  localparam int N = READ_MAX_LENGTH;

  state_e r_state, w_state_next;
  logic [CNT_W-1:0]            r_cnt;
  logic [2*REF_MAX_LENGTH-1:0] r_ref_seq;
  logic [2*N-1:0]              r_read_seq;
  logic [REF_LEN_W-1:0]        r_ref_len;
  logic [READ_LEN_W-1:0]       r_read_len;
  score_t                      r_score;
  logic [REF_IDX_W-1:0]        r_col;
  logic [READ_IDX_W-1:0]       r_row;

  logic w_accept, w_merge_done;
  logic [CNT_W-1:0] w_total;
  logic [REF_LEN_W-1:0]  w_ref_len_clamped;
  logic [READ_LEN_W-1:0] w_read_len_clamped;

  assign w_accept     = (r_state == ST_IDLE) && i_valid;
  assign w_total      = CNT_W'(r_ref_len) + CNT_W'(r_read_len);
  assign w_merge_done = (r_state == ST_MERGE) && (r_cnt == CNT_W'(MERGE_CYCLES - 1));
  assign w_ref_len_clamped = (i_seq_ref_length > REF_LEN_W'(REF_MAX_LENGTH)) ?
                             REF_LEN_W'(REF_MAX_LENGTH) : i_seq_ref_length;
  assign w_read_len_clamped = (i_seq_read_length > READ_LEN_W'(READ_MAX_LENGTH)) ?
                              READ_LEN_W'(READ_MAX_LENGTH) : i_seq_read_length;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_valid) w_state_next = ST_CALC;
      ST_CALC:  if (r_cnt + CNT_W'(1) >= w_total) w_state_next = ST_MERGE;
      ST_MERGE: if (w_merge_done) w_state_next = ST_OUT;
      ST_OUT:   if (i_ready) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_ref_seq  <= '0;
      r_read_seq <= '0;
      r_ref_len  <= '0;
      r_read_len <= '0;
      r_score    <= '0;
      r_col      <= '0;
      r_row      <= '0;
    end else begin
      r_cnt <= (w_state_next != r_state) ? '0 : r_cnt + CNT_W'(1);
      if (w_accept) begin
        r_ref_seq  <= i_sequence_ref;
        r_read_seq <= i_sequence_read;
        r_ref_len  <= w_ref_len_clamped;
        r_read_len <= w_read_len_clamped;
      end else if (r_state == ST_CALC) begin
        r_ref_seq <= {r_ref_seq[2*REF_MAX_LENGTH-3:0], 2'b00};
      end
      if (w_merge_done) begin
        r_score <= w_node_score[1];
        r_col   <= w_node_col[1];
        r_row   <= w_node_row[1];
      end
    end
  end

  // Element k of each chain feeds PE k; PE 0 sees the array boundary (H = F = 0).
  logic                 w_chain_valid [0:N];
  logic [1:0]           w_chain_base  [0:N];
  logic [REF_IDX_W-1:0] w_chain_col   [0:N];
  score_t               w_chain_h     [0:N];
  score_t               w_chain_f     [0:N];
  score_t               w_pe_max      [0:N-1];
  logic [REF_IDX_W-1:0] w_pe_max_col  [0:N-1];
  logic                 w_row_en      [0:N-1];

  assign w_chain_valid[0] = (r_state == ST_CALC) && (r_cnt < CNT_W'(r_ref_len));
  assign w_chain_base[0]  = r_ref_seq[2*REF_MAX_LENGTH-1 -: 2];
  assign w_chain_col[0]   = r_cnt[REF_IDX_W-1:0];
  assign w_chain_h[0]     = '0;
  assign w_chain_f[0]     = '0;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pe
      assign w_row_en[gi] = READ_LEN_W'(gi) < r_read_len;
      sw_pe u_pe (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_accept),
        .i_valid     (w_chain_valid[gi]),
        .i_base_ref  (w_chain_base[gi]),
        .i_base_read (r_read_seq[2*(N-1-gi) +: 2]),
        .i_col       (w_chain_col[gi]),
        .i_row_en    (w_row_en[gi]),
        .i_h_up      (w_chain_h[gi]),
        .i_f_up      (w_chain_f[gi]),
        .o_valid     (w_chain_valid[gi+1]),
        .o_base_ref  (w_chain_base[gi+1]),
        .o_col       (w_chain_col[gi+1]),
        .o_h         (w_chain_h[gi+1]),
        .o_f         (w_chain_f[gi+1]),
        .o_max       (w_pe_max[gi]),
        .o_max_col   (w_pe_max_col[gi])
      );
    end
  endgenerate

  logic w_unused_tail;
  assign w_unused_tail = ^{w_chain_valid[N], w_chain_base[N], w_chain_col[N],
                           w_chain_h[N], w_chain_f[N]};

  // Heap-ordered max tree: leaves N..2N-1 are PEs, node n reduces 2n (lower rows) and 2n+1.
  score_t                w_node_score [1:2*N-1];
  logic [REF_IDX_W-1:0]  w_node_col   [1:2*N-1];
  logic [READ_IDX_W-1:0] w_node_row   [1:2*N-1];

  generate
    for (gi = 0; gi < N; gi++) begin : g_leaf
      assign w_node_score[N+gi] = w_pe_max[gi];
      assign w_node_col[N+gi]   = w_pe_max_col[gi];
      assign w_node_row[N+gi]   = READ_IDX_W'(gi);
    end
    for (gi = 1; gi < N; gi++) begin : g_node
      score_t                r_node_score;
      logic [REF_IDX_W-1:0]  r_node_col;
      logic [READ_IDX_W-1:0] r_node_row;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_node_score <= '0;
          r_node_col   <= '0;
          r_node_row   <= '0;
        end else if (w_node_score[2*gi+1] > w_node_score[2*gi]) begin
          r_node_score <= w_node_score[2*gi+1];
          r_node_col   <= w_node_col[2*gi+1];
          r_node_row   <= w_node_row[2*gi+1];
        end else begin
          r_node_score <= w_node_score[2*gi];
          r_node_col   <= w_node_col[2*gi];
          r_node_row   <= w_node_row[2*gi];
        end
      end
      assign w_node_score[gi] = r_node_score;
      assign w_node_col[gi]   = r_node_col;
      assign w_node_row[gi]   = r_node_row;
    end
  endgenerate

  assign o_ready           = (r_state == ST_IDLE);
  assign o_valid           = (r_state == ST_OUT);
  assign o_alignment_score = r_score;
  assign o_column          = r_col;
  assign o_row             = r_row;
endmodule

// File: tb/tb_sw_align_core.sv
// Randomised and directed bench for sw_align_core against a plain full-matrix SW model.
module tb_sw_align_core;
  import sw_pkg::*;
  localparam int RM = REF_MAX_LENGTH;
  localparam int DM = READ_MAX_LENGTH;

  logic clk = 1'b0;
  logic rst;
  logic o_ready, i_valid, i_ready, o_valid;
  logic [2*RM-1:0] i_sequence_ref;
  logic [2*DM-1:0] i_sequence_read;
  logic [REF_LEN_W-1:0]  i_seq_ref_length;
  logic [READ_LEN_W-1:0] i_seq_read_length;
  logic signed [DP_SW_SCORE_BITWIDTH-1:0] o_alignment_score;
  logic [REF_IDX_W-1:0]  o_column;
  logic [READ_IDX_W-1:0] o_row;

  sw_align_core dut (
    .clk(clk), .rst(rst), .o_ready(o_ready), .i_valid(i_valid),
    .i_sequence_ref(i_sequence_ref), .i_sequence_read(i_sequence_read),
    .i_seq_ref_length(i_seq_ref_length), .i_seq_read_length(i_seq_read_length),
    .i_ready(i_ready), .o_valid(o_valid), .o_alignment_score(o_alignment_score),
    .o_column(o_column), .o_row(o_row)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ref_b  [0:RM-1];
  int read_b [0:DM-1];
  int mh [0:DM][0:RM];
  int me [0:DM][0:RM];
  int mf [0:DM][0:RM];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Textbook affine-gap Smith-Waterman over the whole matrix; strict '>' in row-major
  // order gives the smallest row, then smallest column, on ties.
  task automatic sw_model(input int rl, input int dl, output int bs, output int br, output int bc);
    bs = 0; br = 0; bc = 0;
    for (int i = 0; i <= DM; i++) begin mh[i][0] = 0; me[i][0] = 0; mf[i][0] = 0; end
    for (int j = 0; j <= RM; j++) begin mh[0][j] = 0; me[0][j] = 0; mf[0][j] = 0; end
    for (int i = 1; i <= dl; i++) begin
      for (int j = 1; j <= rl; j++) begin
        int s;
        s = (read_b[i-1] == ref_b[j-1]) ? 2 : -1;
        me[i][j] = imax(mh[i][j-1] - 2, me[i][j-1] - 1);
        mf[i][j] = imax(mh[i-1][j] - 2, mf[i-1][j] - 1);
        mh[i][j] = imax(0, imax(mh[i-1][j-1] + s, imax(me[i][j], mf[i][j])));
        if (mh[i][j] > bs) begin bs = mh[i][j]; br = i - 1; bc = j - 1; end
      end
    end
  endtask

  task automatic start_job(input int rl, input int dl);
    int w;
    w = 0;
    while (!o_ready && w < 100) begin @(negedge clk); w++; end
    check_eq("accept_ready", int'(o_ready), 1);
    for (int k = 0; k < RM; k++) i_sequence_ref[2*RM-1-2*k -: 2] = (k < rl) ? 2'(ref_b[k]) : 2'b00;
    for (int k = 0; k < DM; k++) i_sequence_read[2*DM-1-2*k -: 2] = (k < dl) ? 2'(read_b[k]) : 2'b00;
    i_seq_ref_length  = REF_LEN_W'(rl);
    i_seq_read_length = READ_LEN_W'(dl);
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    i_sequence_ref  = {8{$urandom}};
    i_sequence_read = {8{$urandom}};
  endtask

  task automatic finish_job(input string tag, input int es, input int er, input int ec,
                            input int bound, input int hold);
    int cyc;
    cyc = 0;
    while (!o_valid && cyc < 600) begin @(negedge clk); cyc++; end
    check_eq({tag, "_valid"}, int'(o_valid), 1);
    check_eq({tag, "_latency_in_bound"}, int'(cyc <= bound), 1);
    check_eq({tag, "_score"}, int'(o_alignment_score), es);
    check_eq({tag, "_row"}, int'(o_row), er);
    check_eq({tag, "_col"}, int'(o_column), ec);
    $display("[TB] job %s: score=%0d row=%0d col=%0d latency=%0d", tag,
             o_alignment_score, o_row, o_column, cyc);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq({tag, "_hold_stable"}, int'(o_valid && !o_ready && int'(o_alignment_score) == es
                                           && int'(o_row) == er && int'(o_column) == ec), 1);
    end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, int'(o_valid), 0);
    check_eq({tag, "_ready_back"}, int'(o_ready), 1);
  endtask

  task automatic model_job(input string tag, input int rl, input int dl, input int hold);
    int rc, dc, s, r, c;
    rc = (rl > RM) ? RM : rl;
    dc = (dl > DM) ? DM : dl;
    sw_model(rc, dc, s, r, c);
    start_job(rl, dl);
    finish_job(tag, s, r, c, rc + dc + 8, hold);
  endtask

  task automatic fill(input int rv, input int dv);
    for (int k = 0; k < RM; k++) ref_b[k] = rv;
    for (int k = 0; k < DM; k++) read_b[k] = dv;
  endtask

  initial begin
    int seen;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_sequence_ref = '0; i_sequence_read = '0;
    i_seq_ref_length = '0; i_seq_read_length = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_ready", int'(o_ready), 1);
    check_eq("reset_valid", int'(o_valid), 0);
    check_eq("reset_score", int'(o_alignment_score), 0);
    check_eq("reset_row", int'(o_row), 0);
    check_eq("reset_col", int'(o_column), 0);
    rst = 1'b0;
    @(negedge clk);

    fill(0, 0);
    start_job(128, 128);
    finish_job("identity", 256, 127, 127, 264, 0);

    // Embedded ACGT, with a second i_valid during CALC and a 20-cycle stall on the result.
    fill(3, 0);
    ref_b[10] = 0; ref_b[11] = 1; ref_b[12] = 2; ref_b[13] = 3;
    read_b[0] = 0; read_b[1] = 1; read_b[2] = 2; read_b[3] = 3;
    start_job(128, 4);
    i_seq_ref_length = 8'd5; i_seq_read_length = 8'd5;
    i_valid = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("busy_not_ready", int'(o_ready), 0);
    i_valid = 1'b0;
    finish_job("embedded", 8, 3, 13, 140, 20);

    fill(0, 1);
    start_job(128, 128);
    finish_job("no_similarity", 0, 0, 0, 264, 0);

    fill(0, 0);
    ref_b[4] = 2;
    start_job(9, 8);
    finish_job("gap", 14, 7, 8, 25, 0);

    fill(0, 0);
    start_job(0, 5);
    finish_job("ref_len_zero", 0, 0, 0, 13, 0);
    start_job(5, 0);
    finish_job("read_len_zero", 0, 0, 0, 13, 0);

    for (int k = 0; k < RM; k++) ref_b[k] = $urandom_range(0, 1);
    for (int k = 0; k < DM; k++) read_b[k] = $urandom_range(0, 1);
    model_job("clamp_len", 200, 255, 0);

    // Abort a job mid-CALC; no result may appear, and the next job must be unaffected.
    fill(0, 0);
    start_job(128, 128);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_ready", int'(o_ready), 1);
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      if (o_valid) seen++;
      @(negedge clk);
    end
    check_eq("abort_no_valid", seen, 0);
    for (int k = 0; k < RM; k++) ref_b[k] = $urandom_range(0, 3);
    for (int k = 0; k < DM; k++) read_b[k] = ref_b[(k + 7) % RM];
    model_job("after_abort", 60, 30, 0);

    for (int n = 0; n < 14; n++) begin
      int rl, dl, mode, off;
      rl = (n < 4) ? $urandom_range(1, 12) : $urandom_range(1, RM);
      dl = (n < 4) ? $urandom_range(1, 12) : $urandom_range(1, DM);
      mode = n % 3;
      for (int k = 0; k < RM; k++) ref_b[k] = (mode == 1) ? $urandom_range(0, 1) : $urandom_range(0, 3);
      off = $urandom_range(0, RM - 1);
      for (int k = 0; k < DM; k++) begin
        if (mode == 2 && $urandom_range(0, 7) != 0) read_b[k] = ref_b[(k + off) % RM];
        else read_b[k] = (mode == 1) ? $urandom_range(0, 1) : $urandom_range(0, 3);
      end
      model_job($sformatf("rand%0d", n), rl, dl, (n % 4 == 0) ? 3 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
